// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and a pending-write scoreboard.
// Decode/issue reads and allocates destinations; writeback writes and releases them.
package etcpu_pckg;
    localparam int REG_W = 5;
    localparam int REG_N = 32;
    localparam int REG_S = 32;
endpackage

module regfile_mp_sb #(
    parameter int REG_W  = etcpu_pckg::REG_W,
    parameter int REG_N  = etcpu_pckg::REG_N,
    parameter int REG_S  = etcpu_pckg::REG_S,
    parameter int RP     = 2,
    parameter int WP     = 2,
    parameter int ZERO_R = 1,
    parameter int BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [RP*REG_W-1:0]            rs,
    output logic [RP*REG_S-1:0]            rd,
    output logic [RP-1:0]                  busy,
    input  logic [WP*REG_W-1:0]            wa,
    input  logic [WP*REG_S-1:0]            wd,
    input  logic [WP-1:0]                  we,
    input  logic                           sb_set,
    input  logic [REG_W-1:0]               sb_addr,
    output logic [REG_N-1:0]               pending,
    output logic [$clog2(REG_N+1)-1:0]     pend_cnt
);

    localparam int CW = $clog2(REG_N + 1);

    logic [REG_S-1:0] regs_q [REG_N];
    logic [REG_S-1:0] wr_dat [REG_N];
    logic [REG_N-1:0] hit;
    logic [REG_N-1:0] wr_en;
    logic [REG_N-1:0] set_v;
    logic [REG_N-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        hit   = '0;
        wr_en = '0;
        for (int r = 0; r < REG_N; r++) begin
            wr_dat[r] = '0;
            for (int j = 0; j < WP; j++) begin
                if (rst_n && we[j] && wa[j*REG_W +: REG_W] == REG_W'(r)) begin
                    hit[r]    = 1'b1;
                    wr_dat[r] = wd[j*REG_S +: REG_S];
                end
            end
            wr_en[r] = hit[r] && !(ZERO_R != 0 && r == 0);
        end
    end

    always_comb begin
        rd   = '0;
        busy = '0;
        for (int i = 0; i < RP; i++) begin
            for (int r = 0; r < REG_N; r++) begin
                if (rs[i*REG_W +: REG_W] == REG_W'(r) &&
                    !(ZERO_R != 0 && r == 0)) begin
                    rd[i*REG_S +: REG_S] =
                        (BYPASS != 0 && wr_en[r]) ? wr_dat[r] : regs_q[r];
                    busy[i] = pend_q[r] && !(BYPASS != 0 && hit[r]);
                end
            end
        end
    end

    // A new allocation beats a same-cycle release of the same register.
    always_comb begin
        set_v  = '0;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        for (int r = 0; r < REG_N; r++) begin
            set_v[r]  = sb_set && sb_addr == REG_W'(r) &&
                        !(ZERO_R != 0 && r == 0);
            pend_d[r] = set_v[r] || (pend_q[r] && !hit[r]);
            if (set_v[r] && !pend_q[r]) begin
                cnt_d = cnt_d + CW'(1);
            end
            if (!set_v[r] && pend_q[r] && hit[r]) begin
                cnt_d = cnt_d - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_N; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 0; r < REG_N; r++) begin
                if (wr_en[r]) begin
                    regs_q[r] <= wr_dat[r];
                end
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending  = pend_q;
    assign pend_cnt = cnt_q;

endmodule
